// File: rtl/mv_vector_decode_gen2.sv
// MPEG-2 motion_vectors() parser for one macroblock. Drives the shared motion-code
// VLC decoder and emits one tagged info word per parsed element.
module mv_vector_decode_gen2 #(
  parameter int         F_CODE_MAX = 9,
  parameter logic [7:0] INFO_TAG   = 8'hA5
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        Start_I,
  output logic        Done_O,
  output logic        Error_O,
  input  logic        Data_In_I,
  output logic        Shift_En_O,
  input  logic        Forward_I,
  input  logic        Backward_I,
  input  logic        Intra_I,
  input  logic        Concealment_I,
  input  logic        Mv_Count_I,
  input  logic        Field_Sel_I,
  input  logic        Dmv_I,
  input  logic [15:0] F_Codes_I,
  output logic        Vlc_Start_O,
  input  logic        Vlc_Shift_I,
  input  logic        Vlc_Valid_I,
  input  logic [5:0]  Vlc_Symbol_I,
  output logic [31:0] Buffer_Value_O,
  output logic        Buffer_Write_En_O
);
  // state      | meaning
  // IDLE       | waiting for Start_I, Done_O high
  // FSEL       | consume motion_vertical_field_select bit
  // CODE_START | pulse VLC start, check f_code
  // CODE_WAIT  | VLC decoder pulls bits until symbol valid
  // RESIDUAL   | shift in f-1 residual bits, MSB first
  // DMV0/DMV1  | dmvector first / second bit
  // MARKER     | concealment marker bit
  typedef enum logic [2:0] {
    ST_IDLE, ST_FSEL, ST_CODE_START, ST_CODE_WAIT,
    ST_RESIDUAL, ST_DMV0, ST_DMV1, ST_MARKER
  } state_t;

  localparam int         RW     = F_CODE_MAX - 1;
  localparam logic [4:0] FMAX   = 5'(F_CODE_MAX);
  localparam logic [1:0] K_CODE = 2'b00;
  localparam logic [1:0] K_RES  = 2'b01;
  localparam logic [1:0] K_FSEL = 2'b10;
  localparam logic [1:0] K_DMV  = 2'b11;

  state_t        state_q, state_d, adv_state;
  logic          r_q, s_q, t_q, r_d, s_d, t_d, adv_r, adv_s, adv_t;
  logic          fwd_q, bwd_q, ic_q, mvc_q, fsel_q, dmv_q, err_q;
  logic [15:0]   fcodes_q;
  logic [3:0]    f_cur, cnt_q;
  logic [RW-1:0] res_q, res_nxt;
  logic          f_bad, need_fsel, start_fsel, go_adv, wr_en;
  logic [18:0]   code_mag, code_val, wr_val;
  logic [1:0]    wr_kind;

  always_comb begin
    case ({s_q, t_q})
      2'b00:   f_cur = fcodes_q[15:12];
      2'b01:   f_cur = fcodes_q[11:8];
      2'b10:   f_cur = fcodes_q[7:4];
      default: f_cur = fcodes_q[3:0];
    endcase
  end

  assign f_bad      = (f_cur == 4'd0) || ({1'b0, f_cur} > FMAX);
  assign need_fsel  = mvc_q | (fsel_q & ~dmv_q);
  assign start_fsel = Mv_Count_I | (Field_Sel_I & ~Dmv_I);
  assign res_nxt    = {res_q[RW-2:0], Data_In_I};
  assign code_mag   = {14'd0, Vlc_Symbol_I[4:0]};
  assign code_val   = Vlc_Symbol_I[5] ? (~code_mag + 19'd1) : code_mag;

  // Where to go once an element (t) is fully parsed: t, then r, then s, then marker.
  always_comb begin
    adv_state = ST_IDLE;
    adv_r     = r_q;
    adv_s     = s_q;
    adv_t     = t_q;
    if (!t_q) begin
      adv_t     = 1'b1;
      adv_state = ST_CODE_START;
    end else if (!r_q && mvc_q) begin
      adv_r     = 1'b1;
      adv_t     = 1'b0;
      adv_state = ST_FSEL;
    end else if (!s_q && bwd_q) begin
      adv_s     = 1'b1;
      adv_r     = 1'b0;
      adv_t     = 1'b0;
      adv_state = need_fsel ? ST_FSEL : ST_CODE_START;
    end else if (ic_q) begin
      adv_state = ST_MARKER;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    s_d         = s_q;
    t_d         = t_q;
    Shift_En_O  = 1'b0;
    Vlc_Start_O = 1'b0;
    wr_en       = 1'b0;
    wr_kind     = K_CODE;
    wr_val      = '0;
    go_adv      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start_I) begin
          r_d = 1'b0;
          t_d = 1'b0;
          if (Forward_I | (Intra_I & Concealment_I)) begin
            s_d     = 1'b0;
            state_d = start_fsel ? ST_FSEL : ST_CODE_START;
          end else if (Backward_I) begin
            s_d     = 1'b1;
            state_d = start_fsel ? ST_FSEL : ST_CODE_START;
          end
        end
      end
      ST_FSEL: begin
        Shift_En_O = 1'b1;
        wr_en      = 1'b1;
        wr_kind    = K_FSEL;
        wr_val     = {18'd0, Data_In_I};
        state_d    = ST_CODE_START;
      end
      ST_CODE_START: begin
        Vlc_Start_O = 1'b1;
        state_d     = f_bad ? ST_IDLE : ST_CODE_WAIT;
      end
      ST_CODE_WAIT: begin
        Shift_En_O = Vlc_Shift_I;
        if (Vlc_Valid_I) begin
          wr_en  = 1'b1;
          wr_val = code_val;
          if (f_cur != 4'd1 && Vlc_Symbol_I[4:0] != 5'd0) state_d = ST_RESIDUAL;
          else if (dmv_q) state_d = ST_DMV0;
          else go_adv = 1'b1;
        end
      end
      ST_RESIDUAL: begin
        Shift_En_O = 1'b1;
        if (cnt_q == 4'd0) begin
          wr_en   = 1'b1;
          wr_kind = K_RES;
          wr_val  = 19'(res_nxt);
          if (dmv_q) state_d = ST_DMV0;
          else go_adv = 1'b1;
        end
      end
      ST_DMV0: begin
        Shift_En_O = 1'b1;
        if (Data_In_I) begin
          state_d = ST_DMV1;
        end else begin
          wr_en   = 1'b1;
          wr_kind = K_DMV;
          go_adv  = 1'b1;
        end
      end
      ST_DMV1: begin
        Shift_En_O = 1'b1;
        wr_en      = 1'b1;
        wr_kind    = K_DMV;
        wr_val     = Data_In_I ? 19'h7FFFF : 19'd1;
        go_adv     = 1'b1;
      end
      ST_MARKER: begin
        Shift_En_O = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_adv) begin
      state_d = adv_state;
      r_d     = adv_r;
      s_d     = adv_s;
      t_d     = adv_t;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      t_q      <= 1'b0;
      fwd_q    <= 1'b0;
      bwd_q    <= 1'b0;
      ic_q     <= 1'b0;
      mvc_q    <= 1'b0;
      fsel_q   <= 1'b0;
      dmv_q    <= 1'b0;
      err_q    <= 1'b0;
      fcodes_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s_q     <= s_d;
      t_q     <= t_d;
      if (state_q == ST_IDLE && Start_I) begin
        fwd_q    <= Forward_I;
        bwd_q    <= Backward_I;
        ic_q     <= Intra_I & Concealment_I;
        mvc_q    <= Mv_Count_I;
        fsel_q   <= Field_Sel_I;
        dmv_q    <= Dmv_I;
        fcodes_q <= F_Codes_I;
        err_q    <= 1'b0;
      end
      if (state_q == ST_CODE_START && f_bad) err_q <= 1'b1;
      // Residual down-counter preloads to f-2 so the terminal count lands on the last bit.
      if (state_q == ST_CODE_WAIT && Vlc_Valid_I) begin
        cnt_q <= f_cur - 4'd2;
        res_q <= '0;
      end else if (state_q == ST_RESIDUAL) begin
        cnt_q <= cnt_q - 4'd1;
        res_q <= res_nxt;
      end
    end
  end

  assign Done_O            = (state_q == ST_IDLE);
  assign Error_O           = err_q;
  assign Buffer_Write_En_O = wr_en;
  assign Buffer_Value_O    = wr_en ? {INFO_TAG, r_q, s_q, t_q, wr_kind, wr_val} : 32'd0;

endmodule

// File: tb/tb_mv_vector_decode_gen2.sv
// Table-driven bench for mv_vector_decode_gen2: the bench plays bitstream source and
// VLC decoder, captures info words and compares them with hand-computed vectors.
module tb_mv_vector_decode_gen2;
  logic        clock = 1'b0;
  logic        resetn;
  logic        Start_I, Done_O, Error_O, Data_In_I, Shift_En_O;
  logic        Forward_I, Backward_I, Intra_I, Concealment_I;
  logic        Mv_Count_I, Field_Sel_I, Dmv_I;
  logic [15:0] F_Codes_I;
  logic        Vlc_Start_O, Vlc_Shift_I, Vlc_Valid_I;
  logic [5:0]  Vlc_Symbol_I;
  logic [31:0] Buffer_Value_O;
  logic        Buffer_Write_En_O;

  localparam logic [1:0] K_CODE = 2'b00;
  localparam logic [1:0] K_RES  = 2'b01;
  localparam logic [1:0] K_FSEL = 2'b10;
  localparam logic [1:0] K_DMV  = 2'b11;

  mv_vector_decode_gen2 dut (
    .clock(clock), .resetn(resetn), .Start_I(Start_I), .Done_O(Done_O),
    .Error_O(Error_O), .Data_In_I(Data_In_I), .Shift_En_O(Shift_En_O),
    .Forward_I(Forward_I), .Backward_I(Backward_I), .Intra_I(Intra_I),
    .Concealment_I(Concealment_I), .Mv_Count_I(Mv_Count_I), .Field_Sel_I(Field_Sel_I),
    .Dmv_I(Dmv_I), .F_Codes_I(F_Codes_I), .Vlc_Start_O(Vlc_Start_O),
    .Vlc_Shift_I(Vlc_Shift_I), .Vlc_Valid_I(Vlc_Valid_I), .Vlc_Symbol_I(Vlc_Symbol_I),
    .Buffer_Value_O(Buffer_Value_O), .Buffer_Write_En_O(Buffer_Write_En_O)
  );

  always #5 clock = ~clock;

  // flags = {fwd, bwd, intra, conc, mv_count, field_sel, dmv}; bits consumed MSB first
  typedef struct {
    logic [6:0]        flags;
    logic [15:0]       fc;
    int                nsym;
    logic [7:0][5:0]   sym;
    int                nbit;
    logic [15:0]       bits;
    int                nexp;
    logic [15:0][31:0] ex;
    int                nshift;
    logic              err;
  } vec_t;

  vec_t        tv[9];
  logic        bitq[$];
  logic [5:0]  symq[$];
  logic [31:0] capq[$];
  int          n_tot = 0, n_bad = 0, n_shift = 0, vphase = 0;
  logic        start_req = 1'b0;
  logic        last_wr, last_shift, last_done;
  logic [31:0] last_val;

  function automatic logic [31:0] w(input logic [2:0] rst, input logic [1:0] k, input logic [18:0] v);
    return {8'hA5, rst, k, v};
  endfunction

  function automatic vec_t mkv(input logic [6:0] flags, input logic [15:0] fc, input int nbit,
                               input logic [15:0] bits, input int nshift, input logic err);
    vec_t v;
    v.flags = flags; v.fc = fc; v.nsym = 0; v.sym = '0; v.nbit = nbit; v.bits = bits;
    v.nexp = 0; v.ex = '0; v.nshift = nshift; v.err = err;
    return v;
  endfunction

  task automatic add_sym(input int i, input logic [5:0] s);
    tv[i].sym[tv[i].nsym] = s;
    tv[i].nsym++;
  endtask

  task automatic add_exp(input int i, input logic [31:0] x);
    tv[i].ex[tv[i].nexp] = x;
    tv[i].nexp++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs after negedge, sample outputs 1ns later, model the VLC decoder
  // as one requested bit followed by a valid symbol.
  task automatic cycle();
    @(negedge clock);
    Start_I      = start_req;
    start_req    = 1'b0;
    Data_In_I    = (bitq.size() > 0) ? bitq[0] : 1'b0;
    Vlc_Shift_I  = (vphase == 1);
    Vlc_Valid_I  = (vphase == 2);
    Vlc_Symbol_I = (vphase == 2 && symq.size() > 0) ? symq[0] : 6'd0;
    #1;
    last_wr    = Buffer_Write_En_O;
    last_val   = Buffer_Value_O;
    last_shift = Shift_En_O;
    last_done  = Done_O;
    if (Buffer_Write_En_O) capq.push_back(Buffer_Value_O);
    if (Shift_En_O) begin
      n_shift++;
      if (!Vlc_Shift_I && bitq.size() > 0) bitq.delete(0);
    end
    if (vphase == 2) begin
      if (symq.size() > 0) symq.delete(0);
      vphase = 0;
    end else if (vphase == 1) begin
      vphase = 2;
    end
    if (Vlc_Start_O) vphase = 1;
  endtask

  task automatic load(input vec_t v);
    bitq.delete(); symq.delete(); capq.delete();
    n_shift = 0;
    for (int i = v.nbit - 1; i >= 0; i--) bitq.push_back(v.bits[i]);
    for (int i = 0; i < v.nsym; i++) symq.push_back(v.sym[i]);
    {Forward_I, Backward_I, Intra_I, Concealment_I, Mv_Count_I, Field_Sel_I, Dmv_I} = v.flags;
    F_Codes_I = v.fc;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = tv[idx];
    load(v);
    start_req = 1'b1;
    cycle();
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (last_done) break;
    end
    chk($sformatf("v%0d done", idx), {31'd0, last_done}, 32'd1);
    repeat (2) cycle();
    chk($sformatf("v%0d nwr", idx), 32'(capq.size()), 32'(v.nexp));
    for (int i = 0; i < v.nexp; i++)
      chk($sformatf("v%0d word%0d", idx, i), (i < capq.size()) ? capq[i] : 32'hDEADBEEF, v.ex[i]);
    chk($sformatf("v%0d shifts", idx), 32'(n_shift), 32'(v.nshift));
    chk($sformatf("v%0d error", idx), {31'd0, Error_O}, {31'd0, v.err});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        seen, got;
    int          rs;
    logic [31:0] resw;
    resetn = 1'b0; Start_I = 1'b0; Data_In_I = 1'b0;
    {Forward_I, Backward_I, Intra_I, Concealment_I, Mv_Count_I, Field_Sel_I, Dmv_I} = '0;
    F_Codes_I = '0; Vlc_Shift_I = 1'b0; Vlc_Valid_I = 1'b0; Vlc_Symbol_I = '0;

    tv[0] = mkv(7'b1010000, 16'h1100, 0, 16'h0, 2, 1'b0);
    add_sym(0, 6'h03); add_sym(0, 6'h22);
    add_exp(0, w(3'b000, K_CODE, 19'd3)); add_exp(0, w(3'b001, K_CODE, 19'h7FFFE));
    tv[1] = mkv(7'b1000000, 16'h4100, 3, 16'b101, 5, 1'b0);
    add_sym(1, 6'h05); add_sym(1, 6'h00);
    add_exp(1, w(3'b000, K_CODE, 19'd5)); add_exp(1, w(3'b000, K_RES, 19'd5));
    add_exp(1, w(3'b001, K_CODE, 19'd0));
    tv[2] = mkv(7'b1100100, 16'h2222, 5, 16'b11010, 13, 1'b0);
    add_sym(2, 6'h01);
    for (int i = 0; i < 7; i++) add_sym(2, 6'h00);
    add_exp(2, w(3'b000, K_FSEL, 19'd1)); add_exp(2, w(3'b000, K_CODE, 19'd1));
    add_exp(2, w(3'b000, K_RES, 19'd1));  add_exp(2, w(3'b001, K_CODE, 19'd0));
    add_exp(2, w(3'b100, K_FSEL, 19'd0)); add_exp(2, w(3'b100, K_CODE, 19'd0));
    add_exp(2, w(3'b101, K_CODE, 19'd0)); add_exp(2, w(3'b010, K_FSEL, 19'd1));
    add_exp(2, w(3'b010, K_CODE, 19'd0)); add_exp(2, w(3'b011, K_CODE, 19'd0));
    add_exp(2, w(3'b110, K_FSEL, 19'd0)); add_exp(2, w(3'b110, K_CODE, 19'd0));
    add_exp(2, w(3'b111, K_CODE, 19'd0));
    tv[3] = mkv(7'b1000011, 16'h1100, 3, 16'b011, 5, 1'b0);
    add_sym(3, 6'h00); add_sym(3, 6'h00);
    add_exp(3, w(3'b000, K_CODE, 19'd0)); add_exp(3, w(3'b000, K_DMV, 19'd0));
    add_exp(3, w(3'b001, K_CODE, 19'd0)); add_exp(3, w(3'b001, K_DMV, 19'h7FFFF));
    tv[4] = mkv(7'b0011010, 16'h1100, 2, 16'b11, 4, 1'b0);
    add_sym(4, 6'h21); add_sym(4, 6'h10);
    add_exp(4, w(3'b000, K_FSEL, 19'd1)); add_exp(4, w(3'b000, K_CODE, 19'h7FFFF));
    add_exp(4, w(3'b001, K_CODE, 19'd16));
    tv[5] = mkv(7'b0100001, 16'h0011, 3, 16'b100, 5, 1'b0);
    add_sym(5, 6'h02); add_sym(5, 6'h00);
    add_exp(5, w(3'b010, K_CODE, 19'd2)); add_exp(5, w(3'b010, K_DMV, 19'd1));
    add_exp(5, w(3'b011, K_CODE, 19'd0)); add_exp(5, w(3'b011, K_DMV, 19'd0));
    tv[6] = mkv(7'b1000000, 16'h1000, 0, 16'h0, 1, 1'b1);
    add_sym(6, 6'h01);
    add_exp(6, w(3'b000, K_CODE, 19'd1));
    tv[7] = mkv(7'b0000000, 16'h1111, 0, 16'h0, 0, 1'b0);
    tv[8] = mkv(7'b0100000, 16'h00A0, 0, 16'h0, 0, 1'b1);

    repeat (3) @(negedge clock);
    #1;
    chk("rst done", {31'd0, Done_O}, 32'd1);
    chk("rst error", {31'd0, Error_O}, 32'd0);
    chk("rst shift", {31'd0, Shift_En_O}, 32'd0);
    chk("rst vlc_start", {31'd0, Vlc_Start_O}, 32'd0);
    chk("rst wr_en", {31'd0, Buffer_Write_En_O}, 32'd0);
    chk("rst value", Buffer_Value_O, 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Residual timing with a Start_I pulse while busy.
    load(tv[1]);
    start_req = 1'b1;
    cycle();
    seen = 1'b0; got = 1'b0; rs = 0; resw = '0;
    for (int k = 0; k < 100; k++) begin
      if (k == 3) start_req = 1'b1;
      cycle();
      if (seen && !got) rs += int'(last_shift);
      if (last_wr && last_val[20:19] == K_RES) begin got = 1'b1; resw = last_val; end
      if (last_wr && last_val[20:19] == K_CODE) seen = 1'b1;
      if (last_done) break;
    end
    chk("h2 residual shifts", 32'(rs), 32'd3);
    chk("h2 residual word", resw, w(3'b000, K_RES, 19'd5));
    chk("h2 done", {31'd0, last_done}, 32'd1);
    chk("h2 nwr", 32'(capq.size()), 32'd3);
    chk("h2 error cleared", {31'd0, Error_O}, 32'd0);
    repeat (2) cycle();

    // Reset asserted in the middle of RESIDUAL.
    load(tv[1]);
    start_req = 1'b1;
    cycle();
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (last_wr) break;
    end
    cycle();
    chk("h3 residual shifting", {31'd0, last_shift}, 32'd1);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("h3 abort done", {31'd0, Done_O}, 32'd1);
    chk("h3 abort shift", {31'd0, Shift_En_O}, 32'd0);
    chk("h3 abort wr_en", {31'd0, Buffer_Write_En_O}, 32'd0);
    chk("h3 abort value", Buffer_Value_O, 32'd0);
    chk("h3 abort vlc_start", {31'd0, Vlc_Start_O}, 32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    bitq.delete(); symq.delete(); capq.delete();
    vphase = 0;
    repeat (3) cycle();
    chk("h3 idle after reset", {31'd0, last_done}, 32'd1);
    chk("h3 no writes", 32'(capq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
